uc_datapath: RTL and testbench
==============================

Name: uc_datapath

Overview:
- Processing unit (datapath) directly downstream of `Control_Unit`; consumes its control strobes and returns the carry flag to it.
- Holds accumulator `ACCU`, operand register `R1`, carry flag and the UAL (ALU).
- Memory read data enters on `data_in`; store data leaves on `data_out` toward the RAM.
- Registered state only; UAL result is combinational from `ACCU`/`R1`.

Parameters:
- DATA_W, 8, datapath width in bits (`ACCU`, `R1`, `data_in`, `data_out`, UAL).

Ports:
- clk  input  1  system clock; all registers update on the rising edge
- rst_n  input  1  synchronous reset, active low
- ce  input  1  clock enable; 0 freezes every register
- sel_UAL  input  3  UAL operation select
- load_R1  input  1  capture `data_in` into `R1`
- load_accu  input  1  capture UAL result into `ACCU`
- load_carry  input  1  capture UAL carry into carry flag
- clear_carry  input  1  force carry flag to 0
- data_in  input  DATA_W  memory read data
- data_out  output  DATA_W  current `ACCU` value (store data)
- carry  output  1  registered carry flag to `Control_Unit`
- ual_res  output  DATA_W  combinational UAL result (debug/observe)

Behaviour:
- Reset: on the rising edge with rst_n=0, `ACCU`=0, `R1`=0, carry=0, hence data_out=0.
  - Reset wins over ce and all load strobes.
  - Reset asserted mid-sequence discards any pending load.
- ce=0: all registers hold; strobes ignored; ual_res still tracks the current registers.
- UAL operands: A=`ACCU`, B=`R1`. The UAL is combinational, zero latency to ual_res.
- sel_UAL encoding (result / carry-out c):
  - 000 NOR: ~(A|B), c=0
  - 001 ADD: (A+B) mod 2^DATA_W, c=bit DATA_W of the (DATA_W+1)-bit sum
  - 010 SUB: (A-B) mod 2^DATA_W, c=1 if A<B unsigned (borrow), else 0
  - 011 AND: A&B, c=0
  - 100 OR: A|B, c=0
  - 101 XOR: A^B, c=0
  - 110 PASS_B: B, c=0
  - 111 PASS_A: A, c=0
- Register updates (ce=1, rst_n=1), all on the same edge:
  - load_R1=1: `R1`<=data_in. The new value is visible to the UAL one cycle later.
  - load_accu=1: `ACCU`<=ual_res computed from the pre-edge `ACCU`/`R1`. If load_R1 is high on the same edge, the old `R1` is used.
  - load_carry=1: carry<=c.
  - clear_carry=1: carry<=0. If load_carry is also high, clear_carry wins.
- Latency:
  - Memory word to `R1`: 1 edge.
  - `R1` to `ACCU` via UAL: 1 further edge.
  - `ACCU` to data_out: 0 cycles (data_out is a wire from `ACCU`).
- Wrap-around: ADD/SUB results are truncated to DATA_W; there is no saturation.
- Strobes are level-sensitive per edge. Holding load_accu high for N edges with ADD accumulates `R1` N times.

Optional Feature:
- Macro: UC_ZERO_FLAG_EN.
- Defined:
  - Adds output port `zero` (1 bit), a registered flag updated on exactly the same conditions as carry.
  - On load_carry: `zero` <= (ual_res==0). On clear_carry: `zero` <= 0. Resets to 0.
  - clear_carry priority over load_carry applies identically.
- Undefined: no `zero` port, no extra register; behaviour otherwise identical.

Test Plan:
- Reset/ce:
  - Load `ACCU`=0x5A, assert rst_n=0 for one edge -> data_out=0x00, carry=0.
  - With ce=0 pulse load_R1 (data_in=0xFF) -> `R1` unchanged, ual_res for PASS_B=0x00.
- Load and add:
  - load_R1 data_in=0x3C; then sel=110, load_accu -> data_out=0x3C.
  - Next cycle load_R1 data_in=0xD0; then sel=001, load_accu+load_carry -> data_out=0x0C, carry=1.
- Subtract borrow:
  - `ACCU`=0x05, `R1`=0x07, sel=010, load_accu+load_carry -> data_out=0xFE, carry=1.
  - Then `R1`=0x05, same op on `ACCU`=0x05 -> data_out=0x00, carry=0 (zero=1 with UC_ZERO_FLAG_EN).
- Same-edge hazard:
  - `ACCU`=0x01, `R1`=0x02; one edge with load_R1 (data_in=0x80) and load_accu, sel=001 -> `ACCU`=0x03 (old `R1`), `R1`=0x80.
- Carry priority:
  - carry=1; one edge with load_carry+clear_carry during an ADD producing c=1 -> carry=0.
  - Next edge load_carry alone -> carry=1.
- Logic ops sweep:
  - `ACCU`=0xF0, `R1`=0x3C, sels 000/011/100/101/111 -> ual_res = 0x03/0x30/0xFC/0xCC/0xF0.
  - load_carry on each -> carry=0.

Source files
------------

// File: rtl/uc_datapath.sv
// uc_datapath: ACCU/R1/carry datapath with combinational UAL, driven by Control_Unit strobes.
// Latency: data_in->R1 1 edge, R1->ACCU via UAL 1 edge, ACCU->data_out 0; ual_res is combinational.
// Backpressure: none; ce=0 freezes all registers. Optional `zero` flag under UC_ZERO_FLAG_EN.
module uc_datapath #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic [2:0]        sel_UAL,
   input  logic              load_R1,
   input  logic              load_accu,
   input  logic              load_carry,
   input  logic              clear_carry,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              carry,
`ifdef UC_ZERO_FLAG_EN
   output logic              zero,
`endif
   output logic [DATA_W-1:0] ual_res
);

   typedef enum logic [2:0] {
      OP_NOR    = 3'b000,
      OP_ADD    = 3'b001,
      OP_SUB    = 3'b010,
      OP_AND    = 3'b011,
      OP_OR     = 3'b100,
      OP_XOR    = 3'b101,
      OP_PASS_B = 3'b110,
      OP_PASS_A = 3'b111
   } ual_op_t;

   logic [DATA_W-1:0] accu;
   logic [DATA_W-1:0] r1;
   logic              ual_c;
   logic [DATA_W:0]   sum_ext;
   logic [DATA_W:0]   diff_ext;

   // Extended-width add/subtract; the top bit is the carry / borrow.
   assign sum_ext  = {1'b0, accu} + {1'b0, r1};
   assign diff_ext = {1'b0, accu} - {1'b0, r1};

   // UAL: result and carry-out from the current ACCU (A) and R1 (B).
   always_comb begin
      ual_res = '0;
      ual_c   = 1'b0;
      case (ual_op_t'(sel_UAL))
         OP_NOR:    ual_res = ~(accu | r1);
         OP_ADD:    begin
                       ual_res = sum_ext[DATA_W-1:0];
                       ual_c   = sum_ext[DATA_W];
                    end
         OP_SUB:    begin
                       ual_res = diff_ext[DATA_W-1:0];
                       ual_c   = diff_ext[DATA_W];
                    end
         OP_AND:    ual_res = accu & r1;
         OP_OR:     ual_res = accu | r1;
         OP_XOR:    ual_res = accu ^ r1;
         OP_PASS_B: ual_res = r1;
         OP_PASS_A: ual_res = accu;
         default:   ual_res = '0;
      endcase
   end

   // Operand and accumulator registers; ACCU samples the pre-edge R1 on a same-edge load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         accu <= '0;
         r1   <= '0;
      end else if (ce) begin
         if (load_R1)   r1   <= data_in;
         if (load_accu) accu <= ual_res;
      end
   end

   // Carry flag; clear has priority over load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         carry <= 1'b0;
      end else if (ce) begin
         if (clear_carry)     carry <= 1'b0;
         else if (load_carry) carry <= ual_c;
      end
   end

`ifdef UC_ZERO_FLAG_EN
   // Zero flag tracks the carry flag's update conditions.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero <= 1'b0;
      end else if (ce) begin
         if (clear_carry)     zero <= 1'b0;
         else if (load_carry) zero <= (ual_res == '0);
      end
   end
`endif

   assign data_out = accu;

endmodule

// File: tb/tb_uc_datapath.sv
// Bench for uc_datapath: directed scenarios followed by randomized strobes,
// compared against an arithmetic reference model of ACCU/R1/carry.
module tb_uc_datapath;

   localparam int W   = 8;
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ce;
   logic [2:0]   sel_UAL;
   logic         load_R1, load_accu, load_carry, clear_carry;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;
   logic         carry;
   logic [W-1:0] ual_res;
`ifdef UC_ZERO_FLAG_EN
   logic         zero;
`endif

   int checks   = 0;
   int failures = 0;

   // reference state
   int m_accu  = 0;
   int m_r1    = 0;
   int m_carry = 0;
   int m_zero  = 0;

   uc_datapath #(.DATA_W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ce          (ce),
      .sel_UAL     (sel_UAL),
      .load_R1     (load_R1),
      .load_accu   (load_accu),
      .load_carry  (load_carry),
      .clear_carry (clear_carry),
      .data_in     (data_in),
      .data_out    (data_out),
      .carry       (carry),
`ifdef UC_ZERO_FLAG_EN
      .zero        (zero),
`endif
      .ual_res     (ual_res)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference UAL in plain integer arithmetic.
   function automatic void ref_ual(input int s, input int a, input int b, output int res, output int c);
      c = 0;
      case (s)
         0: res = (~(a | b)) & (MOD - 1);
         1: begin res = (a + b) % MOD; c = ((a + b) >= MOD) ? 1 : 0; end
         2: begin res = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; end
         3: res = a & b;
         4: res = a | b;
         5: res = a ^ b;
         6: res = b;
         default: res = a;
      endcase
   endfunction

   // One clock: drive, check combinational UAL, clock, update model, check registers.
   task automatic step(input logic r, input logic c_e, input logic [2:0] s,
                       input logic lr, input logic la, input logic lc, input logic cc,
                       input logic [W-1:0] din);
      int res, c;
      rst_n = r; ce = c_e; sel_UAL = s;
      load_R1 = lr; load_accu = la; load_carry = lc; clear_carry = cc; data_in = din;
      #1;
      ref_ual(int'(s), m_accu, m_r1, res, c);
      check("ual_res_pre", 32'(ual_res), 32'(res));
      @(posedge clk);
      if (!r) begin
         m_accu = 0; m_r1 = 0; m_carry = 0; m_zero = 0;
      end else if (c_e) begin
         if (la) m_accu = res;
         if (lr) m_r1 = int'(din);
         if (cc) begin
            m_carry = 0; m_zero = 0;
         end else if (lc) begin
            m_carry = c; m_zero = (res == 0) ? 1 : 0;
         end
      end
      #1;
      check("data_out", 32'(data_out), 32'(m_accu));
      check("carry", 32'(carry), 32'(m_carry));
`ifdef UC_ZERO_FLAG_EN
      check("zero", 32'(zero), 32'(m_zero));
`endif
   endtask

   // Convenience: load a value into ACCU through R1 and PASS_B.
   task automatic set_accu(input logic [W-1:0] v);
      step(1, 1, 3'b110, 1, 0, 0, 0, v);
      step(1, 1, 3'b110, 0, 1, 0, 0, 8'h00);
   endtask

   logic [2:0] sweep_sel [5];
   logic [7:0] sweep_exp [5];

   initial begin
      sweep_sel[0] = 3'b000; sweep_exp[0] = 8'h03;
      sweep_sel[1] = 3'b011; sweep_exp[1] = 8'h30;
      sweep_sel[2] = 3'b100; sweep_exp[2] = 8'hFC;
      sweep_sel[3] = 3'b101; sweep_exp[3] = 8'hCC;
      sweep_sel[4] = 3'b111; sweep_exp[4] = 8'hF0;

      rst_n = 0; ce = 1; sel_UAL = 3'b110;
      load_R1 = 0; load_accu = 0; load_carry = 0; clear_carry = 0; data_in = '0;
      @(posedge clk); @(posedge clk); #1;
      check("reset_data_out", 32'(data_out), 32'h00);
      check("reset_carry", 32'(carry), 32'h0);
      check("reset_r1_passb", 32'(ual_res), 32'h00);

      // reset wins over loads
      set_accu(8'h5A);
      check("accu_5a", 32'(data_out), 32'h5A);
      step(0, 1, 3'b001, 1, 1, 1, 0, 8'h77);
      check("rst_over_load", 32'(data_out), 32'h00);
      check("rst_carry", 32'(carry), 32'h0);

      // ce=0 freezes R1
      step(1, 0, 3'b110, 1, 1, 1, 0, 8'hFF);
      step(1, 1, 3'b110, 0, 0, 0, 0, 8'h00);
      check("ce0_passb", 32'(ual_res), 32'h00);

      // load and add with wrap
      set_accu(8'h3C);
      check("pass_b_3c", 32'(data_out), 32'h3C);
      step(1, 1, 3'b110, 1, 0, 0, 0, 8'hD0);
      step(1, 1, 3'b001, 0, 1, 1, 0, 8'h00);
      check("add_wrap", 32'(data_out), 32'h0C);
      check("add_carry", 32'(carry), 32'h1);

      // subtract with and without borrow
      set_accu(8'h05);
      step(1, 1, 3'b110, 1, 0, 0, 0, 8'h07);
      step(1, 1, 3'b010, 0, 1, 1, 0, 8'h00);
      check("sub_borrow_res", 32'(data_out), 32'hFE);
      check("sub_borrow_c", 32'(carry), 32'h1);
      set_accu(8'h05);
      step(1, 1, 3'b010, 0, 1, 1, 0, 8'h00);
      check("sub_zero_res", 32'(data_out), 32'h00);
      check("sub_zero_c", 32'(carry), 32'h0);
`ifdef UC_ZERO_FLAG_EN
      check("sub_zero_flag", 32'(zero), 32'h1);
`endif

      // same-edge R1 load uses old R1
      set_accu(8'h01);
      step(1, 1, 3'b110, 1, 0, 0, 0, 8'h02);
      step(1, 1, 3'b001, 1, 1, 0, 0, 8'h80);
      check("hazard_accu", 32'(data_out), 32'h03);
      step(1, 1, 3'b110, 0, 0, 0, 0, 8'h00);
      check("hazard_r1", 32'(ual_res), 32'h80);

      // clear_carry beats load_carry
      step(1, 1, 3'b110, 1, 0, 0, 0, 8'hFF);
      step(1, 1, 3'b001, 0, 0, 1, 0, 8'h00);
      check("carry_set", 32'(carry), 32'h1);
      step(1, 1, 3'b001, 0, 0, 1, 1, 8'h00);
      check("carry_clear_prio", 32'(carry), 32'h0);
      step(1, 1, 3'b001, 0, 0, 1, 0, 8'h00);
      check("carry_reload", 32'(carry), 32'h1);

      // logic op sweep
      set_accu(8'hF0);
      step(1, 1, 3'b110, 1, 0, 0, 0, 8'h3C);
      for (int i = 0; i < 5; i++) begin
         step(1, 1, sweep_sel[i], 0, 0, 1, 0, 8'h00);
         check("logic_res", 32'(ual_res), 32'(sweep_exp[i]));
         check("logic_carry", 32'(carry), 32'h0);
      end

      // accumulate R1 several times with a held strobe
      set_accu(8'h10);
      step(1, 1, 3'b110, 1, 0, 0, 0, 8'h30);
      for (int i = 0; i < 4; i++) step(1, 1, 3'b001, 0, 1, 0, 0, 8'h00);
      check("accumulate", 32'(data_out), 32'h D0);

      // randomized strobes
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0),
              3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
              8'($urandom_range(0, 255)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
